// File: rtl/cdc_event_scheduler.sv
// Round-robin scheduler that shares one 4-phase req/ack CDC channel
// among N_REQ fast-domain event sources, with a saturating drop counter.
module cdc_event_scheduler #(
    parameter int N_REQ       = 4,
    parameter int ID_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk_fast,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] evt_in,
    input  logic             xfer_ack,
    input  logic             clr_drop,
    output logic             xfer_req,
    output logic [ID_W-1:0]  xfer_id,
    output logic [N_REQ-1:0] pending_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] drop_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RELEASE
    } state_t;

    localparam int PW = $clog2(N_REQ + 1);
    localparam int SW = CNT_W + PW;

    state_t state;
    state_t state_nxt;

    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;

    logic [ID_W-1:0]  last;
    logic [ID_W-1:0]  rr_idx;
    logic [ID_W-1:0]  grant_idx;
    logic             grant_ok;
    logic             do_grant;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] clr_grant;
    logic [N_REQ-1:0] drop_vec;
    logic [PW-1:0]    drop_inc;
    logic [SW-1:0]    drop_sum;

    assign ack_s     = ack_sync[SYNC_STAGES-1];
    assign pending_o = pending;
    assign busy_o    = (state != IDLE);

    // Bring the slow-domain ack into clk_fast through a flop chain.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], xfer_ack};
        end
    end

    // Round-robin search: first pending source after `last`, wrapping.
    always_comb begin
        grant_idx = '0;
        grant_ok  = 1'b0;
        rr_idx    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            rr_idx = ID_W'((int'(last) + k) % N_REQ);
            if (pending[rr_idx]) begin
                grant_idx = rr_idx;
                grant_ok  = 1'b1;
            end
        end
    end

    // Handshake FSM next-state; a grant is only taken from IDLE.
    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        clr_grant = '0;
        unique case (state)
            IDLE: begin
                if (en && grant_ok) begin
                    state_nxt = REQ;
                    do_grant  = 1'b1;
                    clr_grant = N_REQ'(1) << grant_idx;
                end
            end
            REQ: begin
                if (ack_s) state_nxt = RELEASE;
            end
            RELEASE: begin
                if (!ack_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, request level, granted id and round-robin pointer.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            xfer_req <= 1'b0;
            xfer_id  <= '0;
            last     <= ID_W'(N_REQ - 1);
        end else begin
            state <= state_nxt;
            if (do_grant) begin
                xfer_req <= 1'b1;
                xfer_id  <= grant_idx;
                last     <= grant_idx;
            end else if (state == REQ && ack_s) begin
                xfer_req <= 1'b0;
            end
        end
    end

    // Events that hit an already-pending, not-being-granted source are lost.
    always_comb begin
        drop_vec = evt_in & pending & ~clr_grant;
        drop_inc = '0;
        for (int i = 0; i < N_REQ; i++) begin
            drop_inc = drop_inc + PW'(drop_vec[i]);
        end
        drop_sum = SW'(drop_cnt_o) + SW'(drop_inc);
    end

    // Pending flags: a new event wins over the grant clear of the same index.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_grant) | evt_in;
        end
    end

    // Saturating drop counter; clear has priority over increments.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_o <= '0;
        end else if (clr_drop) begin
            drop_cnt_o <= '0;
        end else if (drop_sum > SW'({CNT_W{1'b1}})) begin
            drop_cnt_o <= '1;
        end else begin
            drop_cnt_o <= drop_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_cdc_event_scheduler.sv
// Directed bench for cdc_event_scheduler with a behavioural reference
// model, a delayed slow-side ack responder and per-cycle comparison.
module tb_cdc_event_scheduler;

    localparam int N    = 4;
    localparam int IW   = 2;
    localparam int SY   = 2;
    localparam int CW   = 2;
    localparam int ADLY = 6;
    localparam int MAXD = (1 << CW) - 1;

    logic          clk_fast = 1'b0;
    logic          rst_n    = 1'b0;
    logic          en       = 1'b1;
    logic [N-1:0]  evt_in   = '0;
    logic          xfer_ack = 1'b0;
    logic          clr_drop = 1'b0;
    logic          xfer_req;
    logic [IW-1:0] xfer_id;
    logic [N-1:0]  pending_o;
    logic          busy_o;
    logic [CW-1:0] drop_cnt_o;

    int checks   = 0;
    int failures = 0;
    int glog[$];

    cdc_event_scheduler #(
        .N_REQ(N), .ID_W(IW), .SYNC_STAGES(SY), .CNT_W(CW)
    ) dut (
        .clk_fast  (clk_fast),
        .rst_n     (rst_n),
        .en        (en),
        .evt_in    (evt_in),
        .xfer_ack  (xfer_ack),
        .clr_drop  (clr_drop),
        .xfer_req  (xfer_req),
        .xfer_id   (xfer_id),
        .pending_o (pending_o),
        .busy_o    (busy_o),
        .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_fast = ~clk_fast;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int lg(input int i);
        return (i < glog.size()) ? glog[i] : -1;
    endfunction

    // Reference model: the channel is either free, waiting for ack high
    // (req up) or waiting for ack low; ack is seen SY edges late.
    logic          m_req;
    logic          m_busy;
    int            m_id;
    int            m_last;
    logic [N-1:0]  m_pend;
    int            m_drop;
    logic [SY-1:0] m_ackq;

    always @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            m_req  = 1'b0;
            m_busy = 1'b0;
            m_id   = 0;
            m_last = N - 1;
            m_pend = '0;
            m_drop = 0;
            m_ackq = '0;
        end else begin
            int g;
            int nd;
            logic ack_seen;
            logic [N-1:0] np;
            ack_seen = m_ackq[SY-1];
            g = -1;
            if (!m_busy && en && m_pend != 0) begin
                for (int k = 1; k <= N; k++) begin
                    if (m_pend[(m_last + k) % N]) begin
                        g = (m_last + k) % N;
                        break;
                    end
                end
            end
            nd = 0;
            for (int i = 0; i < N; i++) begin
                if (evt_in[i] && m_pend[i] && i != g) nd++;
                np[i] = (m_pend[i] && i != g) || evt_in[i];
            end
            m_pend = np;
            if (clr_drop) m_drop = 0;
            else m_drop = (m_drop + nd > MAXD) ? MAXD : m_drop + nd;
            if (g >= 0) begin
                m_busy = 1'b1;
                m_req  = 1'b1;
                m_id   = g;
                m_last = g;
            end else if (m_busy && m_req && ack_seen) begin
                m_req = 1'b0;
            end else if (m_busy && !m_req && !ack_seen) begin
                m_busy = 1'b0;
            end
            for (int s = SY - 1; s >= 1; s--) m_ackq[s] = m_ackq[s-1];
            m_ackq[0] = xfer_ack;
        end
    end

    // Per-cycle compare against the model, plus grant logging.
    logic prev_req = 1'b0;
    always @(posedge clk_fast) begin
        #1;
        if (rst_n) begin
            chk("m_req", int'(xfer_req), int'(m_req));
            chk("m_id", int'(xfer_id), m_id);
            chk("m_pend", int'(pending_o), int'(m_pend));
            chk("m_busy", int'(busy_o), int'(m_busy));
            chk("m_drop", int'(drop_cnt_o), m_drop);
            if (xfer_req && !prev_req) glog.push_back(int'(xfer_id));
        end
        prev_req = xfer_req;
    end

    // Slow-side responder: ack follows req after ADLY clk_fast cycles.
    initial begin
        int dly;
        dly = 0;
        forever begin
            @(negedge clk_fast);
            if (!rst_n) begin
                xfer_ack = 1'b0;
                dly = 0;
            end else if (xfer_req != xfer_ack) begin
                dly++;
                if (dly >= ADLY) begin
                    xfer_ack = xfer_req;
                    dly = 0;
                end
            end else begin
                dly = 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk_fast);
        rst_n    = 1'b0;
        evt_in   = '0;
        clr_drop = 1'b0;
        en       = 1'b1;
        repeat (2) @(negedge clk_fast);
        rst_n = 1'b1;
        glog.delete();
    endtask

    task automatic pulse(input logic [N-1:0] v, input int n);
        evt_in = v;
        repeat (n) @(negedge clk_fast);
        evt_in = '0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while ((busy_o || pending_o != 0 || xfer_ack) && n < 300) begin
            @(negedge clk_fast);
            n++;
        end
        chk({nm, "_timeout"}, int'(n < 300), 1);
    endtask

    task automatic wait_free(input string nm);
        int n;
        n = 0;
        while ((busy_o || xfer_ack) && n < 300) begin
            @(negedge clk_fast);
            n++;
        end
        chk({nm, "_timeout"}, int'(n < 300), 1);
    endtask

    task automatic wait_req(input string nm);
        int n;
        n = 0;
        while (!xfer_req && n < 100) begin
            @(negedge clk_fast);
            n++;
        end
        chk({nm, "_timeout"}, int'(n < 100), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk_fast);
        chk("rst_req", int'(xfer_req), 0);
        chk("rst_id", int'(xfer_id), 0);
        chk("rst_pend", int'(pending_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_drop", int'(drop_cnt_o), 0);
        rst_n = 1'b1;
        glog.delete();

        // 1. Single event on source 2
        @(negedge clk_fast);
        evt_in = 4'b0100;
        @(posedge clk_fast);
        #1;
        chk("t1_pend_e0", int'(pending_o), 4'b0100);
        chk("t1_req_e0", int'(xfer_req), 0);
        @(negedge clk_fast);
        evt_in = '0;
        @(posedge clk_fast);
        #1;
        chk("t1_req_e1", int'(xfer_req), 1);
        chk("t1_id_e1", int'(xfer_id), 2);
        chk("t1_pend_e1", int'(pending_o), 0);
        @(negedge clk_fast);
        wait_done("t1");
        chk("t1_drop", int'(drop_cnt_o), 0);
        chk("t1_ngrant", glog.size(), 1);

        // 2. Round robin from reset pointer, then wrap
        do_reset();
        pulse(4'b1111, 1);
        wait_done("t2a");
        chk("t2_g0", lg(0), 0);
        chk("t2_g1", lg(1), 1);
        chk("t2_g2", lg(2), 2);
        chk("t2_g3", lg(3), 3);
        chk("t2_pend", int'(pending_o), 0);
        glog.delete();
        pulse(4'b1001, 1);
        wait_done("t2b");
        chk("t2_w0", lg(0), 0);
        chk("t2_w1", lg(1), 3);
        chk("t2_wn", glog.size(), 2);

        // 3. Coalescing while busy, then re-pend on the grant edge
        do_reset();
        pulse(4'b0001, 1);
        pulse(4'b0010, 4);
        chk("t3_drop", int'(drop_cnt_o), 3);
        wait_done("t3a");
        chk("t3_n", glog.size(), 2);
        chk("t3_g1", lg(1), 1);
        clr_drop = 1'b1;
        @(negedge clk_fast);
        clr_drop = 1'b0;
        chk("t3_clr", int'(drop_cnt_o), 0);
        glog.delete();
        pulse(4'b0100, 2);
        chk("t3_repend", int'(pending_o), 4'b0100);
        chk("t3_rp_req", int'(xfer_req), 1);
        chk("t3_rp_id", int'(xfer_id), 2);
        wait_done("t3b");
        chk("t3_rp_n", glog.size(), 2);
        chk("t3_rp_g1", lg(1), 2);
        chk("t3_rp_drop", int'(drop_cnt_o), 0);

        // 4. Saturation, then clear racing a drop
        do_reset();
        pulse(4'b0001, 1);
        pulse(4'b0010, 6);
        chk("t4_sat", int'(drop_cnt_o), 3);
        chk("t4_busy", int'(busy_o), 1);
        clr_drop = 1'b1;
        evt_in   = 4'b0010;
        @(negedge clk_fast);
        clr_drop = 1'b0;
        evt_in   = '0;
        chk("t4_clrwin", int'(drop_cnt_o), 0);
        wait_done("t4");

        // 5. Enable gating
        do_reset();
        en = 1'b0;
        pulse(4'b0011, 1);
        repeat (10) @(negedge clk_fast);
        chk("t5_noreq", int'(xfer_req), 0);
        chk("t5_nobusy", int'(busy_o), 0);
        chk("t5_pend", int'(pending_o), 4'b0011);
        en = 1'b1;
        @(negedge clk_fast);
        chk("t5_req", int'(xfer_req), 1);
        chk("t5_id", int'(xfer_id), 0);
        en = 1'b0;
        wait_free("t5a");
        repeat (10) @(negedge clk_fast);
        chk("t5_hold", int'(xfer_req), 0);
        chk("t5_hpend", int'(pending_o), 4'b0010);
        chk("t5_hn", glog.size(), 1);
        en = 1'b1;
        wait_done("t5b");
        chk("t5_g1", lg(1), 1);

        // 6. Reset in the middle of a request
        do_reset();
        pulse(4'b0110, 1);
        wait_req("t6");
        chk("t6_pre_pend", int'(pending_o), 4'b0100);
        rst_n = 1'b0;
        #1;
        chk("t6_req", int'(xfer_req), 0);
        chk("t6_pend", int'(pending_o), 0);
        chk("t6_busy", int'(busy_o), 0);
        chk("t6_drop", int'(drop_cnt_o), 0);
        repeat (2) @(negedge clk_fast);
        rst_n = 1'b1;
        glog.delete();
        pulse(4'b1001, 1);
        wait_done("t6b");
        chk("t6_g0", lg(0), 0);
        chk("t6_g1", lg(1), 3);

        repeat (3) @(negedge clk_fast);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
